// File: rtl/branch_target_predictor_pkg.sv
// Shared definitions for the branch target buffer: default widths, counter
// encodings and PC index/tag extraction helpers (also usable by the IF stage
// for debug views of the table).
package branch_target_predictor_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int IDX_W_DEF  = 5;
  localparam int CTR_W_DEF  = 2;
  localparam int TAG_W_DEF  = ADDR_W_DEF - IDX_W_DEF - 2;

  // Direction counter encodings for the default counter width.
  localparam logic [CTR_W_DEF-1:0] CTR_WNT = CTR_W_DEF'((1 << (CTR_W_DEF - 1)) - 1);
  localparam logic [CTR_W_DEF-1:0] CTR_WT  = CTR_W_DEF'(1 << (CTR_W_DEF - 1));
  localparam logic [CTR_W_DEF-1:0] CTR_MAX = '1;

  // Table index: word-aligned PC bits just above the byte offset.
  function automatic logic [IDX_W_DEF-1:0] btb_idx(input logic [ADDR_W_DEF-1:0] pc);
    return IDX_W_DEF'(pc >> 2);
  endfunction

  // Tag: every PC bit above the index.
  function automatic logic [TAG_W_DEF-1:0] btb_tag(input logic [ADDR_W_DEF-1:0] pc);
    return TAG_W_DEF'(pc >> (IDX_W_DEF + 2));
  endfunction

endpackage

// File: rtl/branch_target_predictor_if.sv
// Lookup (IF side), training (EX side) and flush signals of the branch
// target buffer. master = pipeline, slave = predictor.
interface branch_target_predictor_if #(
  parameter int ADDR_W = 32
);

  logic              flush;
  logic [ADDR_W-1:0] lk_pc;
  logic              lk_hit;
  logic              lk_taken;
  logic [ADDR_W-1:0] lk_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;

  modport master (
    output flush, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
    input  lk_hit, lk_taken, lk_target
  );

  modport slave (
    input  flush, lk_pc, upd_en, upd_pc, upd_taken, upd_target,
    output lk_hit, lk_taken, lk_target
  );

endinterface

// File: rtl/branch_target_predictor_sat_ctr.sv
// Combinational next-value unit for an N-bit saturating direction counter:
// increments on taken, decrements on not-taken, never wraps.
module btb_sat_ctr #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt
);

  // Step toward the observed direction, holding at the rails.
  always_comb begin
    nxt = ctr;
    if (taken) begin
      if (ctr != '1) nxt = ctr + 1'b1;
    end else begin
      if (ctr != '0) nxt = ctr - 1'b1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer: tagged entries with a saturating
// direction counter. Lookup is combinational off the flop arrays (no bypass
// of a same-cycle update); training and flush take effect on the next edge.
module branch_target_predictor
  import branch_target_predictor_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDX_W  = IDX_W_DEF,
  parameter int CTR_W  = CTR_W_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  branch_target_predictor_if.slave      bus
);

  localparam int ENTRIES = 2 ** IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] RST_CTR   = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] ALLOC_CTR = CTR_W'(1 << (CTR_W - 1));

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CTR_W-1:0]  ctr_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx, upd_idx;
  logic [TAG_W-1:0]  lk_tag, upd_tag;
  logic              upd_hit;
  logic [CTR_W-1:0]  upd_ctr_nxt;
  logic              unused_pc_lsbs;

  assign lk_idx  = bus.lk_pc[IDX_W+1:2];
  assign lk_tag  = bus.lk_pc[ADDR_W-1:IDX_W+2];
  assign upd_idx = bus.upd_pc[IDX_W+1:2];
  assign upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];

  // Byte offset bits never participate in prediction.
  assign unused_pc_lsbs = ^{bus.lk_pc[1:0], bus.upd_pc[1:0]};

  // Lookup: read the stored entry, forcing clean zeros on a miss.
  always_comb begin
    bus.lk_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bus.lk_taken  = 1'b0;
    bus.lk_target = '0;
    if (bus.lk_hit) begin
      bus.lk_taken  = ctr_q[lk_idx][CTR_W-1];
      bus.lk_target = target_q[lk_idx];
    end
  end

  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  btb_sat_ctr #(.CTR_W(CTR_W)) u_sat_ctr (
    .ctr   (ctr_q[upd_idx]),
    .taken (bus.upd_taken),
    .nxt   (upd_ctr_nxt)
  );

  // Table state: reset clears everything, flush drops valids, else train.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= RST_CTR;
      end
    end else if (bus.flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= upd_ctr_nxt;
        if (bus.upd_taken) target_q[upd_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        // Taken miss replaces whatever lived at this index.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= bus.upd_target;
        ctr_q[upd_idx]    <= ALLOC_CTR;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Randomized and directed check of the branch target buffer against an
// entry-level reference model (default 32-entry, 2-bit counter config).
module tb_branch_target_predictor;

  localparam int ENTRIES = 32;

  logic clk;
  logic rst;

  branch_target_predictor_if #(.ADDR_W(32)) bus();

  branch_target_predictor #(.ADDR_W(32), .IDX_W(5), .CTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one record per table entry.
  bit          m_valid [ENTRIES];
  int unsigned m_tag   [ENTRIES];
  int unsigned m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned idx_of(input int unsigned pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned tag_of(input int unsigned pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
  endtask

  // One clock: drive at negedge, check lookup before the edge, then advance model.
  task automatic cyc(input bit r, input bit f, input bit ue, input int unsigned upc,
                     input bit ut, input int unsigned utgt, input int unsigned lpc,
                     input string name);
    int unsigned li, ui;
    bit e_hit, u_hit;
    @(negedge clk);
    rst = r; bus.flush = f; bus.upd_en = ue; bus.upd_pc = upc;
    bus.upd_taken = ut; bus.upd_target = utgt; bus.lk_pc = lpc;
    #1;
    li = idx_of(lpc);
    e_hit = m_valid[li] && (m_tag[li] == tag_of(lpc));
    check({name, ".hit"},    32'(bus.lk_hit),   32'(e_hit));
    check({name, ".taken"},  32'(bus.lk_taken), 32'(e_hit && (m_ctr[li] >= 2)));
    check({name, ".target"}, bus.lk_target,     e_hit ? m_tgt[li] : 32'h0);
    if (r) begin
      model_reset();
    end else if (f) begin
      for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
    end else if (ue) begin
      ui = idx_of(upc);
      u_hit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
      if (u_hit) begin
        if (ut) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = utgt;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (ut) begin
        m_valid[ui] = 1; m_tag[ui] = tag_of(upc); m_tgt[ui] = utgt; m_ctr[ui] = 2;
      end
    end
  endtask

  initial begin
    int unsigned pc, tgt;
    rst = 1'b1; bus.flush = 1'b0; bus.upd_en = 1'b0; bus.upd_pc = '0;
    bus.upd_taken = 1'b0; bus.upd_target = '0; bus.lk_pc = '0;
    @(posedge clk);
    model_reset();

    // 1: reset state
    cyc(0, 0, 0, 0, 0, 0, 32'h40, "rst_lookup");
    check("rst_hit_const", 32'(bus.lk_hit), 32'h0);

    // 2: allocate, then hit weakly taken
    cyc(0, 0, 1, 32'h40, 1, 32'h100, 32'h40, "alloc");
    cyc(0, 0, 0, 0, 0, 0, 32'h40, "alloc_hit");
    check("alloc_tgt_const", bus.lk_target, 32'h100);

    // 3: hysteresis and saturation at both rails
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 32'h40, 0, 32'hdead, 32'h40, "dec");
    cyc(0, 0, 0, 0, 0, 0, 32'h40, "ctr0");
    check("ctr0_taken_const", 32'(bus.lk_taken), 32'h0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 32'h40, 1, 32'h100, 32'h40, "inc");
    cyc(0, 0, 1, 32'h40, 0, 0, 32'h40, "dec_from3");
    cyc(0, 0, 0, 0, 0, 0, 32'h40, "ctr2");
    check("ctr2_taken_const", 32'(bus.lk_taken), 32'h1);

    // 4: alias replaces victim
    cyc(0, 0, 1, 32'hC0, 1, 32'h200, 32'h40, "alias_upd");
    cyc(0, 0, 0, 0, 0, 0, 32'h40, "alias_old");
    check("alias_old_const", 32'(bus.lk_hit), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'hC0, "alias_new");
    check("alias_new_const", bus.lk_target, 32'h200);

    // 5: same-cycle update and lookup: no bypass
    cyc(0, 0, 1, 32'h80, 1, 32'h300, 32'h80, "same_cyc");
    check("same_cyc_const", 32'(bus.lk_hit), 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 32'h80, "next_cyc");
    check("next_cyc_const", 32'(bus.lk_hit), 32'h1);

    // 6: flush drops concurrent update; rst likewise
    cyc(0, 1, 1, 32'h44, 1, 32'h400, 32'h80, "flush");
    cyc(0, 0, 0, 0, 0, 0, 32'h44, "flush_44");
    cyc(0, 0, 0, 0, 0, 0, 32'hC0, "flush_c0");
    cyc(0, 0, 0, 0, 0, 0, 32'h80, "flush_80");
    cyc(0, 0, 1, 32'h80, 1, 32'h500, 32'h80, "realloc");
    cyc(1, 0, 1, 32'h48, 1, 32'h600, 32'h80, "rst_upd");
    cyc(0, 0, 0, 0, 0, 0, 32'h80, "rst_80");
    cyc(0, 0, 0, 0, 0, 0, 32'h48, "rst_48");

    // Random traffic over a small PC pool to force hits, aliases and saturation.
    for (int n = 0; n < 3000; n++) begin
      pc  = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      tgt = $urandom;
      cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) == 0),
          ($urandom_range(0, 3) != 0), pc, $urandom_range(0, 1), tgt,
          ($urandom_range(0, 3) << 7) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3),
          "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
